// File: rtl/serial_reg_file_pkg.sv
// serial_reg_file_pkg: shared sizing constants
// for the bit-serial register file datapath.
package serial_reg_file_pkg;

  localparam int XLEN       = 32;
  localparam int NREGS      = 32;
  localparam int REG_ADDR_W = 5;
  localparam int BIT_POS_W  = 5;

endpackage

// File: rtl/serial_reg_row.sv
// serial_reg_row: one XLEN-bit register with a
// per-bit write enable and a bit-select read.
module serial_reg_row
  import serial_reg_file_pkg::*;
#(
  parameter int W_XLEN = XLEN,
  parameter int W_POS  = BIT_POS_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [W_POS-1:0] i_bit_pos,
  input  logic             i_data,
  output logic             o_bit
);

  logic [W_XLEN-1:0] r_q;

  // Reset clears the row; otherwise update only the addressed bit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_we) begin
      r_q[i_bit_pos] <= i_data;
    end
  end

  // Combinational bit-select read
  always_comb begin
    o_bit = r_q[i_bit_pos];
  end

endmodule

// File: rtl/serial_reg_file.sv
// serial_reg_file: bit-serial 32x32 register file
// with two read ports; entry 0 reads as zero.
module serial_reg_file
  import serial_reg_file_pkg::*;
#(
  parameter int XLEN_P  = XLEN,
  parameter int NREGS_P = NREGS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data_in,
  input  logic [REG_ADDR_W-1:0] regA_select,
  input  logic [REG_ADDR_W-1:0] regB_select,
  input  logic [BIT_POS_W-1:0]  bitPos,
  input  logic                 writeEn,
  output logic                 portA,
  output logic                 portB
);

  logic [NREGS_P-1:0] w_we;
  logic [NREGS_P-1:0] w_bits;

  // Entry 0 is not stored and never accepts writes
  assign w_we[0]   = 1'b0;
  assign w_bits[0] = 1'b0;

  for (genvar r = 1; r < NREGS_P; r++) begin : g_row
    // Port A's select doubles as the write address
    assign w_we[r] = writeEn &&
      (regA_select == REG_ADDR_W'(r));

    serial_reg_row #(
      .W_XLEN (XLEN_P),
      .W_POS  (BIT_POS_W)
    ) u_row (
      .clk       (clk),
      .rst       (rst),
      .i_we      (w_we[r]),
      .i_bit_pos (bitPos),
      .i_data    (data_in),
      .o_bit     (w_bits[r])
    );
  end

  // Two combinational read muxes, no write bypass
  always_comb begin
    portA = w_bits[regA_select];
    portB = w_bits[regB_select];
  end

endmodule

// File: tb/tb_serial_reg_file.sv
// tb_serial_reg_file: directed self-checking bench
// for the bit-serial register file.
module tb_serial_reg_file;

  logic       clk;
  logic       rst;
  logic       data_in;
  logic [4:0] regA_select;
  logic [4:0] regB_select;
  logic [4:0] bitPos;
  logic       writeEn;
  logic       portA;
  logic       portB;

  int n_tests;
  int n_fail;

  serial_reg_file dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .regA_select (regA_select),
    .regB_select (regB_select),
    .bitPos      (bitPos),
    .writeEn     (writeEn),
    .portA       (portA),
    .portB       (portB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pattern(input int j);
    logic [31:0] v;
    v = 32'(j);
    if (j % 2 == 0) v[31] = 1'b1;
    return v;
  endfunction

  task automatic write_word(input logic [4:0] sel,
                            input logic [31:0] val);
    regA_select = sel;
    writeEn = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bitPos = 5'(i);
      data_in = val[i];
      @(posedge clk);
      #1;
    end
    writeEn = 1'b0;
    data_in = 1'b0;
  endtask

  task automatic read_word(input logic [4:0] sa,
                           input logic [4:0] sb,
                           output logic [31:0] a,
                           output logic [31:0] b);
    writeEn = 1'b0;
    regA_select = sa;
    regB_select = sb;
    for (int i = 0; i < 32; i++) begin
      bitPos = 5'(i);
      #1;
      a[i] = portA;
      b[i] = portB;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] a, b;
    do_reset();
    for (int j = 0; j < 32; j += 7) begin
      read_word(5'(j), 5'(31 - j), a, b);
      n_tests++;
      if (a !== 32'h0 || b !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_state sel=%0d a=%h b=%h exp=0",
                 j, a, b);
      end
    end
  endtask

  task automatic test_store_all();
    logic [31:0] a, b;
    for (int j = 1; j < 32; j++)
      write_word(5'(j), pattern(j));
    for (int j = 1; j < 32; j++) begin
      read_word(5'(j), 5'd0, a, b);
      n_tests++;
      if (a !== pattern(j)) begin
        n_fail++;
        $display("FAIL store_all_a reg=%0d got=%h exp=%h",
                 j, a, pattern(j));
      end
      n_tests++;
      if (b !== 32'h0) begin
        n_fail++;
        $display("FAIL store_all_b reg=%0d got=%h exp=0",
                 j, b);
      end
    end
  endtask

  task automatic test_reg0();
    logic [31:0] a, b;
    write_word(5'd0, 32'hFFFF_FFFF);
    read_word(5'd0, 5'd0, a, b);
    n_tests++;
    if (a !== 32'h0 || b !== 32'h0) begin
      n_fail++;
      $display("FAIL reg0_zero a=%h b=%h exp=0", a, b);
    end
    read_word(5'd1, 5'd2, a, b);
    n_tests++;
    if (a !== 32'h1 || b !== 32'h8000_0002) begin
      n_fail++;
      $display("FAIL reg0_side a=%h b=%h exp=1/80000002",
               a, b);
    end
  endtask

  task automatic test_hold();
    logic [31:0] a, b;
    write_word(5'd7, 32'hA5A5_A5A5);
    regA_select = 5'd7;
    writeEn = 1'b0;
    data_in = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bitPos = 5'(i);
      @(posedge clk);
      #1;
    end
    data_in = 1'b0;
    read_word(5'd7, 5'd7, a, b);
    n_tests++;
    if (a !== 32'hA5A5_A5A5 || b !== 32'hA5A5_A5A5) begin
      n_fail++;
      $display("FAIL hold a=%h b=%h exp=a5a5a5a5", a, b);
    end
  endtask

  task automatic test_parallel();
    logic [31:0] ea, eb;
    ea = 32'h1234_5678;
    eb = 32'hDEAD_BEEF;
    write_word(5'd5, ea);
    write_word(5'd9, eb);
    regA_select = 5'd5;
    regB_select = 5'd9;
    for (int i = 0; i < 32; i++) begin
      bitPos = 5'(i);
      #1;
      n_tests++;
      if (portA !== ea[i] || portB !== eb[i]) begin
        n_fail++;
        $display("FAIL parallel bit=%0d a=%b b=%b exp=%b/%b",
                 i, portA, portB, ea[i], eb[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a, b;
    int bad;
    regA_select = 5'd10;
    writeEn = 1'b1;
    data_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bitPos = 5'(i);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    writeEn = 1'b0;
    data_in = 1'b0;
    bad = 0;
    for (int j = 0; j < 32; j++) begin
      read_word(5'(j), 5'(j), a, b);
      if (a !== 32'h0 || b !== 32'h0) begin
        bad++;
        $display("FAIL reset_mid reg=%0d a=%h b=%h exp=0",
                 j, a, b);
      end
    end
    n_tests++;
    if (bad != 0) n_fail++;
    write_word(5'd3, 32'h0000_00F0);
    read_word(5'd3, 5'd10, a, b);
    n_tests++;
    if (a !== 32'h0000_00F0 || b !== 32'h0) begin
      n_fail++;
      $display("FAIL resume a=%h b=%h exp=000000f0/0", a, b);
    end
  endtask

  task automatic test_rdw();
    do_reset();
    regA_select = 5'd4;
    regB_select = 5'd4;
    bitPos = 5'd3;
    data_in = 1'b1;
    writeEn = 1'b1;
    #1;
    n_tests++;
    if (portA !== 1'b0 || portB !== 1'b0) begin
      n_fail++;
      $display("FAIL rdw_before a=%b b=%b exp=0", portA, portB);
    end
    @(posedge clk);
    #1;
    writeEn = 1'b0;
    data_in = 1'b0;
    #1;
    n_tests++;
    if (portA !== 1'b1 || portB !== 1'b1) begin
      n_fail++;
      $display("FAIL rdw_after a=%b b=%b exp=1", portA, portB);
    end
    bitPos = 5'd2;
    #1;
    n_tests++;
    if (portA !== 1'b0) begin
      n_fail++;
      $display("FAIL rdw_neighbor a=%b exp=0", portA);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    rst = 1'b1;
    data_in = 1'b0;
    regA_select = 5'd0;
    regB_select = 5'd0;
    bitPos = 5'd0;
    writeEn = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_store_all();
    test_reg0();
    test_hold();
    test_parallel();
    test_reset_mid();
    test_rdw();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
